// File: rtl/instr_encoder_pkg.sv
// Shared types and encoding constants for the instruction encoder.
// Op codes, RV32 major opcodes, func3/func7 fields and the FSM state type.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_SLL  = 4'd5,
        OP_ADDI = 4'd6,
        OP_SLLI = 4'd7,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9,
        OP_BEQ  = 4'd10,
        OP_JAL  = 4'd11,
        OP_JALR = 4'd12,
        OP_HALT = 4'd13
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // HALT is a reserved all-ones opcode with every other field zero
    localparam logic [31:0] HALT_WORD = 32'h0000_007F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO buffering encoded words between the encoder and memory.
// DEPTH must be a power of two, at least 2; head entry is shown on rdata.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // extra pointer bit distinguishes full from empty when indices match
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: encodes instruction requests into 32-bit words, buffers
// them and writes them to consecutive instruction-memory addresses.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting instruction requests
// DRAIN | HALT accepted, flushing buffered words to memory
// DONE  | one-cycle completion pulse, then back to IDLE
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_e      state;
    state_e      state_nxt;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic        wrapped;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_op)
            OP_ADD:  enc_word = {F7_BASE, in_rs2, in_rs1, F3_ADD, in_rd, OPC_OP};
            OP_SUB:  enc_word = {F7_SUB,  in_rs2, in_rs1, F3_ADD, in_rd, OPC_OP};
            OP_MUL:  enc_word = {F7_MUL,  in_rs2, in_rs1, F3_ADD, in_rd, OPC_OP};
            OP_AND:  enc_word = {F7_BASE, in_rs2, in_rs1, F3_AND, in_rd, OPC_OP};
            OP_OR:   enc_word = {F7_BASE, in_rs2, in_rs1, F3_OR,  in_rd, OPC_OP};
            OP_SLL:  enc_word = {F7_BASE, in_rs2, in_rs1, F3_SLL, in_rd, OPC_OP};
            OP_ADDI: enc_word = {in_imm[11:0], in_rs1, F3_ADD, in_rd, OPC_OP_IMM};
            OP_SLLI: enc_word = {F7_BASE, in_imm[4:0], in_rs1, F3_SLL, in_rd, OPC_OP_IMM};
            OP_LW:   enc_word = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OPC_LOAD};
            OP_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OPC_STORE};
            OP_BEQ:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ,
                                 in_imm[4:1], in_imm[11], OPC_BRANCH};
            OP_JAL:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, OPC_JAL};
            OP_JALR: enc_word = {in_imm[11:0], in_rs1, F3_JALR, in_rd, OPC_JALR};
            OP_HALT: enc_word = HALT_WORD;
            default: enc_legal = 1'b0;
        endcase
    end

    // illegal ops complete the handshake but never reach the buffer
    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = mem_we && mem_ready;

    instr_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .wdata(enc_word),
        .pop  (pop),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign mem_we    = !fifo_empty;
    assign mem_wdata = fifo_empty ? 32'h0 : fifo_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = !fifo_full;
                if (accept && (in_op == OP_HALT)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // wrapped remembers that the all-ones address was written; any later write is an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            err      <= 1'b0;
            wrapped  <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            mem_addr <= start_addr;
            err      <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            if (pop) begin
                mem_addr <= mem_addr + 1'b1;
                if (&mem_addr) wrapped <= 1'b1;
                if (wrapped)   err     <= 1'b1;
            end
            if (accept && !enc_legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected {addr, word} pairs are queued when
// a request is accepted and compared in order as memory writes complete.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [20:0] in_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_mis = 0;
    int n_wr  = 0;
    int n_pushed = 0;
    logic [7:0]  exp_addr;
    logic [39:0] sb[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    function automatic logic [31:0] model(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [20:0] imm);
        case (op)
            4'd0:  return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd1:  return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd2:  return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd3:  return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            4'd4:  return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            4'd5:  return {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
            4'd6:  return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            4'd7:  return {7'b0000000, imm[4:0], rs1, 3'b001, rd, 7'b0010011};
            4'd8:  return {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            4'd9:  return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            4'd10: return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            4'd11: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            4'd12: return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            default: return 32'h0000007F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // memory side: every completed write must match the oldest expectation
    always @(negedge clk) begin
        logic [39:0] e;
        if (mem_we === 1'b1 && mem_ready === 1'b1) begin
            n_wr++;
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_mis++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write",
                       mem_addr, mem_wdata);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                assert ({mem_addr, mem_wdata} === e) else begin
                    n_mis++;
                    $error("FAIL write: observed addr %h data %h expected addr %h data %h",
                           mem_addr, mem_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] a);
        start = 1'b1;
        start_addr = a;
        exp_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [20:0] imm, input logic [31:0] exp_w);
        int guard = 0;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("handshake", {31'b0, in_ready}, 32'h1);
        if (in_ready === 1'b1) begin
            @(posedge clk);
            n_pushed++;
            if (op <= 4'd13) begin
                sb.push_back({exp_addr, exp_w});
                exp_addr = exp_addr + 8'd1;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        int extra = 0;
        while (done !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", {31'b0, done}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("done_once", extra, 0);
        chk("busy_after_done", {31'b0, busy}, 32'h0);
        chk("sb_drained", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int acc;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; in_valid = 1'b0; in_op = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; mem_ready = 1'b1; exp_addr = '0;
        repeat (3) @(posedge clk); #1;

        chk("rst_in_ready",  {31'b0, in_ready}, 32'h0);
        chk("rst_mem_we",    {31'b0, mem_we}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_addr",  {24'b0, mem_addr}, 32'h0);
        chk("rst_busy",      {31'b0, busy}, 32'h0);
        chk("rst_done",      {31'b0, done}, 32'h0);
        chk("rst_err",       {31'b0, err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic load, including a start pulse while busy that must be ignored
        do_start(8'h10);
        chk("run_busy", {31'b0, busy}, 32'h1);
        chk("run_no_early_we", {31'b0, mem_we}, 32'h0);
        send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 32'h002081B3);
        send(4'd6, 5'd1, 5'd0, 5'd0, 21'd5, 32'h00500093);
        send(4'd9, 5'd0, 5'd1, 5'd2, 21'd8, 32'h0020A423);
        send(4'd10, 5'd0, 5'd1, 5'd2, 21'd8, 32'h00208463);
        start = 1'b1; start_addr = 8'h99;
        @(posedge clk); #1;
        start = 1'b0;
        send(4'd13, 5'd0, 5'd0, 5'd0, 21'd0, 32'h0000007F);
        wait_done();
        chk("err_clean_load", {31'b0, err}, 32'h0);
        in_valid = 1'b1; in_op = 4'd0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) acc++;
        end
        in_valid = 1'b0;
        chk("idle_no_accept", acc, 0);
        @(posedge clk); #1;

        // back-pressure: buffer fills after four words, nothing lost once released
        do_start(8'h20);
        mem_ready = 1'b0;
        n_pushed = 0;
        fork
            begin
                send(4'd1, 5'd4, 5'd5, 5'd6, 21'd0, model(4'd1, 5'd4, 5'd5, 5'd6, 21'd0));
                send(4'd2, 5'd7, 5'd8, 5'd9, 21'd0, model(4'd2, 5'd7, 5'd8, 5'd9, 21'd0));
                send(4'd3, 5'd10, 5'd11, 5'd12, 21'd0, model(4'd3, 5'd10, 5'd11, 5'd12, 21'd0));
                send(4'd4, 5'd13, 5'd14, 5'd15, 21'd0, model(4'd4, 5'd13, 5'd14, 5'd15, 21'd0));
                send(4'd5, 5'd16, 5'd17, 5'd18, 21'd0, model(4'd5, 5'd16, 5'd17, 5'd18, 21'd0));
                send(4'd7, 5'd19, 5'd20, 5'd0, 21'h1F3, model(4'd7, 5'd19, 5'd20, 5'd0, 21'h1F3));
            end
            begin
                int g = 0;
                while (n_pushed < 4 && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                @(negedge clk);
                chk("full_in_ready", {31'b0, in_ready}, 32'h0);
                chk("full_mem_we", {31'b0, mem_we}, 32'h1);
                repeat (5) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        send(4'd11, 5'd1, 5'd0, 5'd0, 21'h0ABCD, model(4'd11, 5'd1, 5'd0, 5'd0, 21'h0ABCD));
        send(4'd12, 5'd2, 5'd3, 5'd0, 21'h1FFFFC, model(4'd12, 5'd2, 5'd3, 5'd0, 21'h1FFFFC));
        send(4'd8, 5'd5, 5'd6, 5'd0, 21'h007FF, model(4'd8, 5'd5, 5'd6, 5'd0, 21'h007FF));
        send(4'd10, 5'd0, 5'd7, 5'd8, 21'h1FF7E, model(4'd10, 5'd0, 5'd7, 5'd8, 21'h1FF7E));
        send(4'd13, 5'd0, 5'd0, 5'd0, 21'd0, 32'h0000007F);
        wait_done();

        // illegal op is consumed without a write and leaves err set
        wr0 = n_wr;
        do_start(8'h40);
        send(4'd0, 5'd5, 5'd6, 5'd7, 21'd0, model(4'd0, 5'd5, 5'd6, 5'd7, 21'd0));
        send(4'd15, 5'd1, 5'd1, 5'd1, 21'd0, 32'h0);
        chk("err_after_illegal", {31'b0, err}, 32'h1);
        send(4'd0, 5'd8, 5'd9, 5'd10, 21'd0, model(4'd0, 5'd8, 5'd9, 5'd10, 21'd0));
        send(4'd13, 5'd0, 5'd0, 5'd0, 21'd0, 32'h0000007F);
        wait_done();
        chk("illegal_write_count", n_wr - wr0, 3);
        repeat (3) @(posedge clk); #1;
        chk("err_sticky_idle", {31'b0, err}, 32'h1);

        // address wrap: writing past the all-ones address flags err
        do_start(8'hFF);
        chk("err_cleared_by_start", {31'b0, err}, 32'h0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 21'd0, model(4'd0, 5'd1, 5'd2, 5'd3, 21'd0));
        send(4'd0, 5'd4, 5'd5, 5'd6, 21'd0, model(4'd0, 5'd4, 5'd5, 5'd6, 21'd0));
        send(4'd13, 5'd0, 5'd0, 5'd0, 21'd0, 32'h0000007F);
        wait_done();
        chk("err_after_wrap", {31'b0, err}, 32'h1);

        // reset during DRAIN with three words buffered
        mem_ready = 1'b0;
        do_start(8'h80);
        send(4'd0, 5'd1, 5'd1, 5'd1, 21'd0, model(4'd0, 5'd1, 5'd1, 5'd1, 21'd0));
        send(4'd1, 5'd2, 5'd2, 5'd2, 21'd0, model(4'd1, 5'd2, 5'd2, 5'd2, 21'd0));
        send(4'd13, 5'd0, 5'd0, 5'd0, 21'd0, 32'h0000007F);
        chk("drain_busy", {31'b0, busy}, 32'h1);
        chk("drain_mem_we", {31'b0, mem_we}, 32'h1);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        chk("mid_rst_addr", {24'b0, mem_addr}, 32'h0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h0);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("mid_rst_hold_we", {31'b0, mem_we}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(8'h05);
        send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 32'h002081B3);
        send(4'd13, 5'd0, 5'd0, 5'd0, 21'd0, 32'h0000007F);
        wait_done();
        chk("post_rst_err", {31'b0, err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
